// File: rtl/serial_pattern_feeder_if.sv
// Word handshake into the serial pattern feeder.
// The master offers s_data with s_valid. The slave accepts with s_ready.
interface serial_pattern_feeder_if #(
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/serial_pattern_feeder.sv
// Serialises parallel words onto bit_out, one bit per clock.
// A single holding register lets the next word follow with no idle gap.
module serial_pattern_feeder #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  restn,
  serial_pattern_feeder_if.slave s_if,
  input  logic                  flush,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  word_done,
  output logic                  busy
);
  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_live;   // low until the first edge after reset release

  logic              w_xfer;
  logic              w_last;
  logic              w_head;
  logic [DATA_W-1:0] w_sh_next;

  // The hold register may only be written while it is empty, so s_ready drops once it fills.
  assign s_if.s_ready = r_live & ((r_state == IDLE) | ~r_hold_full);
  assign w_xfer       = s_if.s_valid & s_if.s_ready;
  assign w_last       = (r_cnt == LAST);

  // Select the bit order. The head bit is always the next bit to leave.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_head    = r_sh[DATA_W-1];
      assign w_sh_next = {r_sh[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign w_head    = r_sh[0];
      assign w_sh_next = {1'b0, r_sh[DATA_W-1:1]};
    end
  endgenerate

  assign bit_out   = (r_state == SHIFT) ? w_head : IDLE_BIT;
  assign bit_valid = (r_state == SHIFT);
  assign word_done = (r_state == SHIFT) & w_last;
  assign busy      = (r_state == SHIFT) | r_hold_full;

  // Control FSM, shifter and holding register. A flush overrides every other update.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_state     <= IDLE;
        r_hold_full <= 1'b0;
        r_cnt       <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_xfer) begin
              r_sh    <= s_if.s_data;
              r_cnt   <= '0;
              r_state <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_last) begin
              r_cnt <= '0;
              if (r_hold_full) begin
                r_sh        <= r_hold;
                r_hold_full <= 1'b0;
              end else if (w_xfer) begin
                r_sh <= s_if.s_data;   // bypass: the word goes straight into the shifter
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_sh  <= w_sh_next;
              r_cnt <= r_cnt + 1'b1;
              if (w_xfer) begin
                r_hold      <= s_if.s_data;
                r_hold_full <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Scoreboard bench: each accepted word pushes its expected bit sequence,
// and the bits are popped and compared as the DUTs emit them.
module tb_serial_pattern_feeder;
  logic clk = 1'b0;
  logic restn;
  logic a_flush, b_flush;
  logic a_bo, a_bv, a_wd, a_busy;
  logic b_bo, b_bv, b_wd, b_busy;

  serial_pattern_feeder_if #(.DATA_W(8)) a_if ();
  serial_pattern_feeder_if #(.DATA_W(8)) b_if ();

  serial_pattern_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .restn(restn), .s_if(a_if), .flush(a_flush),
    .bit_out(a_bo), .bit_valid(a_bv), .word_done(a_wd), .busy(a_busy));

  serial_pattern_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .restn(restn), .s_if(b_if), .flush(b_flush),
    .bit_out(b_bo), .bit_valid(b_bv), .word_done(b_wd), .busy(b_busy));

  always #5 clk = ~clk;

  typedef struct { logic b; logic last; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   a_done = 0;
  int   b_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Push the expected bits of every accepted word. A flush drops everything pending.
  always @(posedge clk) begin : sb_push_a
    exp_t e;
    if (a_flush) qa.delete();
    else if (restn && a_if.s_valid && a_if.s_ready)
      for (int i = 0; i < 8; i++) begin
        e.b = a_if.s_data[7-i]; e.last = (i == 7); qa.push_back(e);
      end
  end

  always @(posedge clk) begin : sb_push_b
    exp_t e;
    if (b_flush) qb.delete();
    else if (restn && b_if.s_valid && b_if.s_ready)
      for (int i = 0; i < 8; i++) begin
        e.b = b_if.s_data[i]; e.last = (i == 7); qb.push_back(e);
      end
  end

  // A reset loses both the word in flight and the held word.
  always @(negedge restn) begin
    qa.delete();
    qb.delete();
  end

  // Compare emitted bits away from the active edge.
  always @(negedge clk) begin : sb_pop_a
    exp_t e;
    if (a_wd) a_done++;
    if (a_bv) begin
      if (qa.size() == 0) chk("a_extra_bit", a_bv, 1'b0);
      else begin
        e = qa.pop_front();
        chk("a_bit", a_bo, e.b);
        chk("a_word_done", a_wd, e.last);
      end
    end else if (qa.size() != 0) chk("a_gap", a_bv, 1'b1);
    else chk("a_idle", {a_bo, a_wd, a_busy}, 3'b000);
  end

  always @(negedge clk) begin : sb_pop_b
    exp_t e;
    if (b_wd) b_done++;
    if (b_bv) begin
      if (qb.size() == 0) chk("b_extra_bit", b_bv, 1'b0);
      else begin
        e = qb.pop_front();
        chk("b_bit", b_bo, e.b);
        chk("b_word_done", b_wd, e.last);
      end
    end else if (qb.size() != 0) chk("b_gap", b_bv, 1'b1);
    else chk("b_idle", {b_bo, b_wd, b_busy}, 3'b000);
  end

  // Offer a word and hold s_valid until it is accepted. The caller lowers s_valid.
  task automatic send_a(input logic [7:0] w);
    logic rdy;
    logic ok;
    ok = 1'b0;
    a_if.s_valid = 1'b1;
    a_if.s_data  = w;
    for (int i = 0; i < 64; i++) begin
      rdy = a_if.s_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    chk("a_sent", ok, 1'b1);
  endtask

  task automatic send_b(input logic [7:0] w);
    logic rdy;
    logic ok;
    ok = 1'b0;
    b_if.s_valid = 1'b1;
    b_if.s_data  = w;
    for (int i = 0; i < 64; i++) begin
      rdy = b_if.s_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    chk("b_sent", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int base;
    restn = 1'b0;
    a_flush = 1'b0; b_flush = 1'b0;
    a_if.s_valid = 1'b0; a_if.s_data = '0;
    b_if.s_valid = 1'b0; b_if.s_data = '0;
    #2;
    chk("rst_outs", {a_bo, a_bv, a_wd, a_busy}, 4'b0000);
    chk("rst_ready", a_if.s_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 restn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", a_if.s_ready, 1'b1);

    // Single MSB-first word: D4 -> 1,1,0,1,0,1,0,0.
    base = a_done;
    send_a(8'hD4);
    a_if.s_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("t1_done_cnt", a_done - base, 1);

    // LSB-first word: 2B -> 1,1,0,1,0,1,0,0.
    base = b_done;
    send_b(8'h2B);
    b_if.s_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("t2_done_cnt", b_done - base, 1);
    chk("t2_idle_bit", b_bo, 1'b0);

    // Streaming with s_valid held high. The hold register fills and s_ready drops.
    base = a_done;
    send_a(8'hFF);
    send_a(8'h00);
    chk("t3_ready_hold", a_if.s_ready, 1'b0);
    chk("t3_busy", a_busy, 1'b1);
    send_a(8'hAA);
    a_if.s_valid = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("t3_done_cnt", a_done - base, 3);

    // The second word is offered only on the last-bit cycle, so it takes the bypass path.
    base = a_done;
    send_a(8'h96);
    a_if.s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_wd) break;
      @(posedge clk); #1;
    end
    chk("t4_last_bit_seen", a_wd, 1'b1);
    a_if.s_valid = 1'b1;
    a_if.s_data  = 8'h3C;
    @(posedge clk); #1;
    a_if.s_valid = 1'b0;
    chk("t4_bypass_ready", a_if.s_ready, 1'b1);
    chk("t4_bypass_valid", a_bv, 1'b1);
    repeat (12) @(posedge clk); #1;
    chk("t4_done_cnt", a_done - base, 2);

    // Flush after 3 bits while a word is held. The held word must never appear.
    base = a_done;
    send_a(8'hD4);
    send_a(8'h5A);
    a_if.s_valid = 1'b0;
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    chk("t5_bit_valid", a_bv, 1'b0);
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_ready", a_if.s_ready, 1'b1);
    chk("t5_bit_out", a_bo, 1'b0);
    repeat (15) @(posedge clk); #1;
    chk("t5_done_cnt", a_done - base, 0);

    // Asynchronous reset in the middle of a word.
    send_a(8'hD4);
    a_if.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 restn = 1'b0;
    #1;
    chk("t6_bit_valid", a_bv, 1'b0);
    chk("t6_busy", a_busy, 1'b0);
    chk("t6_word_done", a_wd, 1'b0);
    chk("t6_ready", a_if.s_ready, 1'b0);
    @(posedge clk); #2 restn = 1'b1;
    @(posedge clk); #1;
    base = a_done;
    send_a(8'hD4);
    a_if.s_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("t6_done_cnt", a_done - base, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
